// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store path.
// It accepts one request at a time and responds after a fixed LATENCY. The response is held until the requester accepts it.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic       ONE_CYCLE = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          cur_wen_s;
    logic [31:0]   cur_addr_s;
    logic [31:0]   cur_wdata_s;
    logic [3:0]    cur_be_s;
    logic          err_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   rdata_s;
    logic          enter_resp_s;
    logic          mem_we_s;

    function automatic logic addr_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
    endfunction

    // Operands: request port for a one-cycle access straight out of IDLE, latched copy otherwise.
    always_comb begin
        cur_wen_s    = (state_q == S_IDLE) ? req_wen   : wen_q;
        cur_addr_s   = (state_q == S_IDLE) ? req_addr  : addr_q;
        cur_wdata_s  = (state_q == S_IDLE) ? req_wdata : wdata_q;
        cur_be_s     = (state_q == S_IDLE) ? req_be    : be_q;
        err_s        = addr_err(cur_addr_s);
        idx_s        = cur_addr_s[AW+1:2];
        rdata_s      = (!cur_wen_s && !err_s) ? mem_q[idx_s] : 32'h0000_0000;
        enter_resp_s = ((state_q == S_IDLE) && req_valid && ONE_CYCLE) ||
                       ((state_q == S_WAIT) && (cnt_q == 4'd0));
        mem_we_s     = enter_resp_s && cur_wen_s && !err_s;
    end

    // Storage array: byte-masked write on the edge that enters RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be_s[i]) begin
                    mem_q[idx_s][8*i +: 8] <= cur_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Request/response sequencing and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            wen_q        <= 1'b0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            be_q         <= 4'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        wen_q   <= req_wen;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        if (ONE_CYCLE) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'h0000_0000;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (enter_resp_s) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= rdata_s;
                resp_err_q   <= err_s;
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 4, 1), a directed table, hand-written timing sequences,
// and random traffic checked against a word-array model.
module tb_dmem_responder;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid  [3];
    logic        req_wen    [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [3:0]  req_be     [3];
    logic        resp_ready [3];
    logic        req_ready  [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int checks = 0;
    int failures = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_wen(req_wen[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One complete transaction with resp_ready held high. lat counts edges after the accept edge
    // before resp_valid is seen; the FSM gives LATENCY-1 (valid is sampled by the requester at edge k+LATENCY).
    task automatic do_req(input int u, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err, output int lat);
        int n;
        n = 0;
        req_wen[u] = wen; req_addr[u] = addr; req_wdata[u] = wdata; req_be[u] = be;
        resp_ready[u] = 1'b1;
        req_valid[u] = 1'b1;
        while (!req_ready[u] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_within_bound", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        req_valid[u] = 1'b0;
        lat = 0;
        while (!resp_valid[u] && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        rdata = resp_rdata[u];
        err = resp_err[u];
        @(posedge clk); #1;
    endtask

    function automatic logic model_err(input logic [31:0] a);
        return ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= 32'(DEPTH));
    endfunction

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        tbl [14];
    logic [31:0] model [int];
    logic [31:0] rd;
    logic        er;
    int          lt;

    initial begin
        for (int u = 0; u < 3; u++) begin
            req_valid[u] = 1'b0; req_wen[u] = 1'b0; req_addr[u] = 32'h0;
            req_wdata[u] = 32'h0; req_be[u] = 4'h0; resp_ready[u] = 1'b1;
        end

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 1'b0, 32'h0000_0000};
        tbl[3]  = '{1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0000_0000};
        tbl[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h3, 1'b0, 32'h11BB33DD};
        tbl[5]  = '{1'b0, 32'h0000_0022, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000};
        tbl[6]  = '{1'b1, 32'h0000_0000, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0000_0000};
        tbl[7]  = '{1'b1, 32'h0000_1000, 32'h12345678, 4'hF, 1'b1, 32'h0000_0000};
        tbl[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 1'b0, 32'hCAFEF00D};
        tbl[9]  = '{1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0000_0000};
        tbl[10] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 1'b0, 32'h11BB33DD};
        tbl[11] = '{1'b1, 32'h0000_0013, 32'h99999999, 4'hF, 1'b1, 32'h0000_0000};
        tbl[12] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 1'b0, 32'hDEADBEEF};
        tbl[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            chk("reset_resp_valid", resp_valid[u], 32'd0);
            chk("reset_resp_rdata", resp_rdata[u], 32'd0);
            chk("reset_resp_err", resp_err[u], 32'd0);
            chk("reset_req_ready", req_ready[u], 32'd0);
        end
        reset = 1'b0;
        #1;
        for (int u = 0; u < 3; u++) chk("post_reset_req_ready", req_ready[u], 32'd1);
        @(posedge clk); #1;

        // Directed table on the LATENCY=2 instance
        for (int i = 0; i < 14; i++) begin
            do_req(0, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er, lt);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
            chk($sformatf("tbl%0d_latency", i), lt, 32'd1);
        end

        // Backpressure: load 0x10 with resp_ready low for 5 cycles
        req_wen[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'h0; resp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", resp_valid[0], 32'd1);
            chk("bp_rdata", resp_rdata[0], 32'hDEADBEEF);
            chk("bp_err", resp_err[0], 32'd0);
            chk("bp_req_ready", req_ready[0], 32'd0);
            @(posedge clk); #1;
        end
        resp_ready[0] = 1'b1;
        chk("bp_valid_before_release", resp_valid[0], 32'd1);
        chk("bp_ready_before_release", req_ready[0], 32'd0);
        @(posedge clk); #1;
        chk("bp_valid_cleared", resp_valid[0], 32'd0);
        chk("bp_rdata_cleared", resp_rdata[0], 32'd0);
        chk("bp_req_ready_rises", req_ready[0], 32'd1);

        // Reset abort on the LATENCY=4 instance
        do_req(1, 1'b1, 32'h30, 32'h0000_0000, 4'hF, rd, er, lt);
        chk("abort_pre_store_err", er, 32'd0);
        chk("abort_pre_store_latency", lt, 32'd3);
        req_wen[1] = 1'b1; req_addr[1] = 32'h30; req_wdata[1] = 32'h55AA55AA; req_be[1] = 4'hF;
        req_valid[1] = 1'b1;
        chk("abort_ready_at_accept", req_ready[1], 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("abort_busy_after_accept", req_ready[1], 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_rst_resp_valid", resp_valid[1], 32'd0);
        chk("abort_rst_resp_rdata", resp_rdata[1], 32'd0);
        chk("abort_rst_resp_err", resp_err[1], 32'd0);
        chk("abort_rst_req_ready", req_ready[1], 32'd0);
        @(posedge clk); #1;
        chk("abort_rst_hold_valid", resp_valid[1], 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        do_req(1, 1'b0, 32'h30, 32'h0, 4'hF, rd, er, lt);
        chk("abort_load_rdata", rd, 32'h0000_0000);
        chk("abort_load_err", er, 32'd0);

        // LATENCY=1, back-to-back with req_valid held high
        begin
            int   last;
            int   nacc;
            logic rdy;
            last = -1;
            nacc = 0;
            req_wen[2] = 1'b1; req_addr[2] = 32'h40; req_wdata[2] = 32'h0BADF00D; req_be[2] = 4'hF;
            resp_ready[2] = 1'b1;
            req_valid[2] = 1'b1;
            for (int c = 0; c < 12; c++) begin
                rdy = req_ready[2];
                @(posedge clk); #1;
                if (rdy) begin
                    chk("b2b_valid_after_accept", resp_valid[2], 32'd1);
                    chk("b2b_err", resp_err[2], 32'd0);
                    if (last >= 0) chk("b2b_spacing", 32'(c - last), 32'd2);
                    last = c;
                    nacc++;
                end else begin
                    chk("b2b_valid_gap", resp_valid[2], 32'd0);
                end
            end
            req_valid[2] = 1'b0;
            chk("b2b_accept_count", 32'(nacc), 32'd6);
            @(posedge clk); #1;
        end
        do_req(2, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lt);
        chk("b2b_load_rdata", rd, 32'h0BADF00D);
        chk("b2b_load_latency", lt, 32'd0);

        // Random traffic on the LATENCY=2 instance against the word model
        for (int w = 0; w < 16; w++) begin
            logic [31:0] v;
            v = $urandom;
            do_req(0, 1'b1, 32'h200 + 32'(4 * w), v, 4'hF, rd, er, lt);
            model[128 + w] = v;
            chk("rnd_init_err", er, 32'd0);
        end
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] tmp;
            logic [31:0] exp_rd;
            logic [3:0]  be;
            logic        wen;
            logic        exp_er;
            int          r;
            r   = int'($urandom_range(0, 9));
            wen = 1'($urandom_range(0, 1));
            wd  = $urandom;
            be  = 4'($urandom_range(0, 15));
            if (r == 0) begin
                a = 32'h200 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            end else if (r == 1) begin
                tmp = $urandom;
                a = (tmp | 32'h0000_1000) & 32'hFFFF_FFFC;
            end else begin
                a = 32'h200 + 32'(4 * $urandom_range(0, 15));
            end
            exp_er = model_err(a);
            exp_rd = 32'h0;
            if (!exp_er && !wen) exp_rd = model[int'(a / 32'd4)];
            if (!exp_er && wen) begin
                for (int i = 0; i < 4; i++) begin
                    if (((be >> i) & 4'd1) != 4'd0)
                        model[int'(a / 32'd4)] = (model[int'(a / 32'd4)] & ~(32'hFF << (8 * i))) |
                                                 (wd & (32'hFF << (8 * i)));
                end
            end
            do_req(0, wen, a, wd, be, rd, er, lt);
            chk($sformatf("rnd%0d_rdata a=%h", t, a), rd, exp_rd);
            chk($sformatf("rnd%0d_err a=%h", t, a), er, exp_er);
            chk($sformatf("rnd%0d_latency", t), lt, 32'd1);
        end
        for (int w = 0; w < 16; w++) begin
            do_req(0, 1'b0, 32'h200 + 32'(4 * w), 32'h0, 4'h0, rd, er, lt);
            chk($sformatf("rnd_final_w%0d", w), rd, model[128 + w]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
